// File: rtl/uart_tx_arbiter.sv
// Four-requester frame arbiter in front of a UART serializer: rotating-priority
// frame grants, byte-at-a-time handoff under CTS flow control, sticky stall timeout.
module uart_tx_arbiter #(
  parameter logic [31:0] CTS_TIMEOUT = 32'd1_200_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [3:0]  grant,
  input  logic        cts,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [1:0]  last_owner, last_owner_nxt;
  logic [3:0]  grant_nxt;
  logic [7:0]  tx_data_nxt;
  logic        tx_start_nxt;
  logic        last_q, last_nxt;
  logic        terr_nxt;
  logic [31:0] stall_cnt, stall_nxt;
  logic [1:0]  pick, cand;
  logic        pick_vld;
  logic        accept;
  logic [7:0]  owner_byte;

  // Rotating priority: search upward starting just after the previous owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!pick_vld && req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign accept     = (state == SEND) && req_valid[owner] && !cts && !tx_busy;
  assign req_ready  = accept ? (4'b0001 << owner) : 4'b0000;
  assign owner_byte = req_data[{owner, 3'b000} +: 8];

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    grant_nxt      = grant;
    tx_data_nxt    = tx_data;
    tx_start_nxt   = 1'b0;
    last_nxt       = last_q;
    terr_nxt       = timeout_err;
    stall_nxt      = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick;
          grant_nxt = 4'b0001 << pick;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_nxt  = owner_byte;
          tx_start_nxt = 1'b1;
          last_nxt     = req_last[owner];
          state_nxt    = WAIT_ACK;
        end else if (stall_cnt == CTS_TIMEOUT - 32'd1) begin
          // Stalled too long: drop the frame and pass priority on.
          terr_nxt       = 1'b1;
          grant_nxt      = '0;
          last_owner_nxt = owner;
          state_nxt      = IDLE;
        end else begin
          stall_nxt = stall_cnt + 32'd1;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_nxt      = '0;
            last_owner_nxt = owner;
            state_nxt      = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= 2'd3;
      grant       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      last_q      <= 1'b0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      grant       <= grant_nxt;
      tx_data     <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      last_q      <= last_nxt;
      timeout_err <= terr_nxt;
      stall_cnt   <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte queues, a 3-cycle serializer model,
// and a scoreboard of expected {byte, owner} pairs checked at every tx_start.
module tb_uart_tx_arbiter;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        cts = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CTS_TIMEOUT(32'(TMO))) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .cts(cts),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .timeout_err(timeout_err)
  );

  typedef struct packed { logic [7:0] d; logic [3:0] g; } exp_t;
  typedef struct { logic [3:0] valid; logic [7:0] base; int owner; } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] qd[4][$];
  bit         ql[4][$];
  int         n_chk = 0, n_err = 0;
  int         bcnt = 0;
  bit         clr_on_acc = 1'b0;
  logic [3:0] last_acc = '0;
  vec_t       vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    qd[i].push_back(d);
    ql[i].push_back(l);
  endtask

  task automatic expect_b(input logic [7:0] d, input int o);
    exp_q.push_back({d, 4'(1 << o)});
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = qd[i].size() != 0;
      req_data[8*i +: 8] = (qd[i].size() != 0) ? qd[i][0] : 8'h00;
      req_last[i]        = (ql[i].size() != 0) ? ql[i][0] : 1'b0;
    end
  endtask

  // One clock: sample handshake before the edge, then update serializer and producers.
  task automatic tick();
    logic [3:0] acc;
    logic       st;
    #1;
    acc = req_ready & req_valid;
    st  = tx_start;
    last_acc = acc;
    @(posedge clk);
    #1;
    if (st) begin tx_busy = 1'b1; bcnt = 2; end
    else if (bcnt != 0) bcnt--;
    else tx_busy = 1'b0;
    for (int i = 0; i < 4; i++)
      if (acc[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    if (acc != 0 && clr_on_acc) clear_q();
    drive();
  endtask

  task automatic run_idle(input int bound, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || grant != 0) && n < bound) begin
      tick();
      n++;
    end
    chk({nm, " completion"}, 32'(exp_q.size() == 0 && grant == 0), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cts = 1'b0;
    clr_on_acc = 1'b0;
    clear_q();
    drive();
    tick();
    tick();
    reset = 1'b0;
    tx_busy = 1'b0;
    bcnt = 0;
  endtask

  // Scoreboard: every load strobe must match the next expected byte and owner.
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected tx_start: got data %0h grant %0h want none", tx_data, grant);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_data", {24'h0, tx_data}, {24'h0, mon_e.d});
        chk("grant at tx_start", {28'h0, grant}, {28'h0, mon_e.g});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b0001, 8'hA5, 0};
    vecs[1] = '{4'b0110, 8'h40, 1};
    vecs[2] = '{4'b0101, 8'h50, 2};
    vecs[3] = '{4'b1001, 8'h60, 3};
    vecs[4] = '{4'b0011, 8'h70, 0};
    vecs[5] = '{4'b1000, 8'h80, 3};
    vecs[6] = '{4'b0111, 8'h90, 0};
    vecs[7] = '{4'b1110, 8'hB0, 1};

    do_reset();
    chk("reset grant", {28'h0, grant}, 32'h0);
    chk("reset tx_start", {31'h0, tx_start}, 32'h0);
    chk("reset tx_data", {24'h0, tx_data}, 32'h0);
    chk("reset timeout_err", {31'h0, timeout_err}, 32'h0);
    chk("reset req_ready", {28'h0, req_ready}, 32'h0);

    // Single-byte frames; expected owners follow the rotating priority chain.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++)
        if (vecs[v].valid[i]) push(i, vecs[v].base + 8'(i), 1'b1);
      expect_b(vecs[v].base + 8'(vecs[v].owner), vecs[v].owner);
      clr_on_acc = 1'b1;
      drive();
      tick();
      chk($sformatf("vec%0d grant", v), {28'h0, grant}, 32'(1 << vecs[v].owner));
      run_idle(40, $sformatf("vec%0d", v));
      clr_on_acc = 1'b0;
      chk($sformatf("vec%0d idle tx_start", v), {31'h0, tx_start}, 32'h0);
    end

    // Contention: all four hold 1-byte frames, two rounds.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        push(i, 8'h10 + 8'(i), 1'b1);
        expect_b(8'h10 + 8'(i), i);
      end
    drive();
    run_idle(300, "contention");

    // Frame lock: req1 arrives mid-frame and must wait for byte 03.
    do_reset();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    expect_b(8'h01, 0); expect_b(8'h02, 0); expect_b(8'h03, 0);
    drive();
    tick();
    tick();
    push(1, 8'h20, 1'b1);
    expect_b(8'h20, 1);
    drive();
    run_idle(100, "frame lock");

    // CTS held off for 10 SEND cycles, below the timeout.
    do_reset();
    cts = 1'b1;
    push(0, 8'h77, 1'b1);
    expect_b(8'h77, 0);
    drive();
    tick();
    chk("cts grant", {28'h0, grant}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("cts req_ready", {28'h0, last_acc}, 32'h0);
    end
    cts = 1'b0;
    run_idle(40, "cts resume");
    chk("cts timeout_err", {31'h0, timeout_err}, 32'h0);

    // Timeout: abort on the 16th stalled SEND cycle, then requester 3 goes next.
    do_reset();
    cts = 1'b1;
    push(2, 8'h55, 1'b1);
    push(3, 8'h66, 1'b1);
    drive();
    tick();
    chk("tmo grant", {28'h0, grant}, 32'h4);
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("tmo err before limit", {31'h0, timeout_err}, 32'h0);
    chk("tmo grant before limit", {28'h0, grant}, 32'h4);
    tick();
    chk("tmo err at limit", {31'h0, timeout_err}, 32'h1);
    chk("tmo grant cleared", {28'h0, grant}, 32'h0);
    cts = 1'b0;
    expect_b(8'h66, 3);
    expect_b(8'h55, 2);
    run_idle(60, "tmo recovery");
    chk("tmo err sticky", {31'h0, timeout_err}, 32'h1);

    // Reset during WAIT_DONE of byte 1: byte 2 must never start.
    do_reset();
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b1);
    expect_b(8'h31, 1);
    drive();
    begin
      int n = 0;
      while (!tx_busy && n < 20) begin tick(); n++; end
    end
    chk("midreset busy seen", {31'h0, tx_busy}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    chk("midreset grant", {28'h0, grant}, 32'h0);
    chk("midreset tx_start", {31'h0, tx_start}, 32'h0);
    chk("midreset tx_data", {24'h0, tx_data}, 32'h0);
    chk("midreset req_ready", {28'h0, req_ready}, 32'h0);
    reset = 1'b0;
    clear_q();
    drive();
    for (int k = 0; k < 12; k++) tick();
    chk("midreset idle grant", {28'h0, grant}, 32'h0);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
